// File: rtl/conv3d_psum_acc_if.sv
// Partial-sum in / OFM out stream bundle
// for the conv3D partial-sum accumulator.
interface conv3d_psum_acc_if #(
  parameter int W  = 32,
  parameter int AW = 11
) ();
  logic          psum_valid;
  logic          psum_ready;
  logic [W-1:0]  psum_data;
  logic          ofm_valid;
  logic          ofm_ready;
  logic [W-1:0]  ofm_data;
  logic [AW-1:0] ofm_addr;
  logic          ofm_last;

  modport slave (
    input  psum_valid,
    input  psum_data,
    input  ofm_ready,
    output psum_ready,
    output ofm_valid,
    output ofm_data,
    output ofm_addr,
    output ofm_last
  );

  modport master (
    output psum_valid,
    output psum_data,
    output ofm_ready,
    input  psum_ready,
    input  ofm_valid,
    input  ofm_data,
    input  ofm_addr,
    input  ofm_last
  );
endinterface

// File: rtl/conv3d_psum_acc.sv
// Accumulates per-channel conv3D partial sums
// in a plane buffer and streams final OFM values.
module conv3d_psum_acc #(
  parameter int OFM_DIM    = 24,
  parameter int IFM_DEPTH  = 2,
  parameter int OFM_DEPTH  = 2,
  parameter int PSUM_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic done,
  conv3d_psum_acc_if.slave bus
);
  localparam int PLANE = OFM_DIM * OFM_DIM;
  localparam int TOTAL = OFM_DEPTH * PLANE;
  localparam int AW =
    TOTAL > 1 ? $clog2(TOTAL) : 1;
  localparam int JW =
    OFM_DIM > 1 ? $clog2(OFM_DIM) : 1;
  localparam int DW =
    IFM_DEPTH > 1 ? $clog2(IFM_DEPTH) : 1;
  localparam int FW =
    OFM_DEPTH > 1 ? $clog2(OFM_DEPTH) : 1;
  localparam int PW =
    PLANE > 1 ? $clog2(PLANE) : 1;

  logic [JW-1:0] j;
  logic [JW-1:0] i;
  logic [DW-1:0] d;
  logic [FW-1:0] f;
  logic j_end, i_end, d_end, f_end;
  logic frame_end;
  logic acc, hs;
  logic [PW-1:0] p;
  logic [AW-1:0] addr;

  logic [PSUM_WIDTH-1:0] plane [PLANE];
  logic [PSUM_WIDTH-1:0] rd;
  logic [PSUM_WIDTH-1:0] sum;

  logic                  o_valid;
  logic [PSUM_WIDTH-1:0] o_data;
  logic [AW-1:0]         o_addr;
  logic                  o_last;

  assign j_end = (j == JW'(OFM_DIM - 1));
  assign i_end = (i == JW'(OFM_DIM - 1));
  assign d_end = (d == DW'(IFM_DEPTH - 1));
  assign f_end = (f == FW'(OFM_DEPTH - 1));
  assign frame_end =
    d_end & j_end & i_end & f_end;

  // The last pass may only issue when the
  // output register is free or draining now.
  assign bus.psum_ready =
    !d_end || !o_valid || bus.ofm_ready;
  assign acc = bus.psum_valid & bus.psum_ready;
  assign hs  = o_valid & bus.ofm_ready;

  assign p = PW'(32'(i) * OFM_DIM + 32'(j));
  assign addr =
    AW'(32'(f) * PLANE + 32'(p));

  assign rd  = plane[p];
  assign sum = (IFM_DEPTH == 1)
             ? bus.psum_data
             : rd + bus.psum_data;

  assign bus.ofm_valid = o_valid;
  assign bus.ofm_data  = o_data;
  assign bus.ofm_addr  = o_addr;
  assign bus.ofm_last  = o_last;

  // Plane buffer: first pass overwrites,
  // middle passes accumulate, last pass reads.
  always_ff @(posedge clk) begin
    if (acc && !clear && !d_end) begin
      if (d == '0)
        plane[p] <= bus.psum_data;
      else
        plane[p] <= rd + bus.psum_data;
    end
  end

  // Position counters, j fastest then i, d, f.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j <= '0;
      i <= '0;
      d <= '0;
      f <= '0;
    end else if (clear) begin
      j <= '0;
      i <= '0;
      d <= '0;
      f <= '0;
    end else if (acc) begin
      if (!j_end) begin
        j <= j + 1'b1;
      end else begin
        j <= '0;
        if (!i_end) begin
          i <= i + 1'b1;
        end else begin
          i <= '0;
          if (!d_end) begin
            d <= d + 1'b1;
          end else begin
            d <= '0;
            f <= f_end ? '0 : f + 1'b1;
          end
        end
      end
    end
  end

  // Output register with back-to-back reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_addr  <= '0;
      o_last  <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= hs & o_last;
      if (acc && d_end) begin
        o_valid <= 1'b1;
        o_data  <= sum;
        o_addr  <= addr;
        o_last  <= frame_end;
      end else if (hs) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end
endmodule
